mist_frame_trig: RTL and testbench
==================================

Name: mist_frame_trig

Overview:
- Producer side of the simulation dump-control interface.
- Turns the video vertical sync and the ROM-download flag into the signals the dump consumer needs:
  - a frame counter;
  - a per-frame strobe;
  - a dump-window enable, with start and stop strobes;
  - a sticky simulation-finish request.
- Sits beside the game top in the test harness, observing VGA_VS and the download LED.
- Synthesizable, so the same frame numbering also drives on-target debug triggers.

Parameters:
- DUMP_START, 0, frame number at which the dump window opens.
- DUMP_LEN, 0, window length in frames; 0 = window never closes.
- MAXFRAME, 0, frame number at which sim_finish is raised; 0 = never.
- CW, 32, frame counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- vs  in  1  vertical sync, asynchronous to clk; a frame ends on its falling edge.
- downloading  in  1  ROM download in progress (LED); level, synchronous to clk.
- frame_cnt  out  CW  frames completed since download end.
- frame_stb  out  1  one-cycle pulse when frame_cnt advances.
- dump_en  out  1  high while the dump window is open.
- dump_start_stb  out  1  one-cycle pulse on the cycle dump_en rises.
- dump_stop_stb  out  1  one-cycle pulse on the cycle dump_en falls.
- sim_finish  out  1  sticky finish request.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, sync chain and edge register 0.
- VS path:
  - 2-flop synchronizer, then an edge register.
  - A falling edge is detected when the edge register is 1 and sync[1] is 0.
  - The edge is registered, so frame_stb asserts on the 3rd rising clk after vs falls.
  - Because the edge register resets to 0, vs held low out of reset gives no strobe.
- Counter:
  - frame_cnt and frame_stb update on the same edge.
  - frame_cnt saturates at all-ones; frame_stb still pulses at saturation.
  - Neither counts while downloading=1.
- FSM states: IDLE, PRE, DUMP, POST.
  - IDLE: frame_cnt held 0. On downloading=0, go to DUMP if DUMP_START==0, else PRE. dump_en and dump_start_stb assert on that same edge (1 cycle after downloading falls).
  - PRE: on frame_stb where the new frame_cnt == DUMP_START, go to DUMP; dump_en=1, dump_start_stb=1 on that edge.
  - DUMP: if DUMP_LEN!=0, then on frame_stb where the new frame_cnt == DUMP_START+DUMP_LEN (CW-bit sum, saturating), go to POST; dump_en=0, dump_stop_stb=1.
  - POST: terminal until downloading rises or reset.
- sim_finish:
  - Set on the frame_stb edge where the new frame_cnt == MAXFRAME, MAXFRAME!=0.
  - Clears only on reset; unaffected by downloading.
- Download rising mid-operation, from any non-IDLE state:
  - Next edge: state to IDLE, frame_cnt to 0.
  - If dump_en was 1: dump_en=0 and dump_stop_stb=1 on that edge.
  - A frame_stb pending in the same cycle is discarded.
- Simultaneous events:
  - Start and stop on the same frame cannot occur, since DUMP_LEN>=1 when nonzero.
  - sim_finish may coincide with a start or stop strobe; both are honoured.
- Asynchronous reset mid-window: outputs drop to 0 immediately; no dump_stop_stb is emitted.

Decomposition:
- Shared package mist_dump_pkg: FSM state enum (IDLE, PRE, DUMP, POST) and the default CW.
- One sub-module, mist_vs_edge: 2-flop synchronizer plus registered falling-edge pulse, ports clk, rst_n, vs, fall_stb.

Test Plan:
- Reset release with vs=0 and downloading=0; DUMP_START=0 -> dump_en=1 and dump_start_stb=1 one cycle after reset release; no frame_stb until the first genuine vs 1->0 transition.
- downloading=1 for 1000 cycles with 3 vs falls, then 0; DUMP_START=2 -> frame_cnt stays 0 during download; dump_start_stb fires on the 2nd frame_stb after download ends, 3 clks after that vs fall.
- DUMP_START=2, DUMP_LEN=3 -> dump_en high across frame_cnt 2..4; dump_stop_stb on the edge frame_cnt becomes 5; state POST; further frames give no strobes.
- MAXFRAME=4 -> sim_finish rises with frame_cnt=4 and stays high through a later downloading pulse.
- downloading rises while frame_cnt=3 and dump_en=1 -> next edge frame_cnt=0, dump_en=0, dump_stop_stb=1; a vs fall in that same cycle produces no frame_stb.
- CW=4 with 20 frames -> frame_cnt saturates at 15; frame_stb keeps pulsing; no second dump_start_stb.

Source files
------------

// File: rtl/mist_dump_pkg.sv
// Shared definitions for the simulation dump-control producer:
// dump FSM state encoding and the default frame counter width.
package mist_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DUMP = 2'd2,
        POST = 2'd3
    } dump_state_e;

    localparam int DEFAULT_CW = 32;

endpackage

// File: rtl/mist_vs_edge.sv
// Vertical-sync front end: brings the asynchronous vs into the clk domain
// through a two-flop synchronizer and flags its falling edge against an
// edge register. fall_stb is the detect term of those registers; the
// consumer registers it together with the frame counter so that the strobe
// lands on the third rising clk after vs falls.
module mist_vs_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic fall_stb
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       edge_q;
    logic       edge_d;

    // Next-state for the synchronizer chain and the edge register.
    always_comb begin
        sync_d = {sync_q[0], vs};
        edge_d = sync_q[1];
    end

    // Synchronizer and edge flops; all clear so vs low out of reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign fall_stb = edge_q & ~sync_q[1];

endmodule

// File: rtl/mist_frame_trig.sv
// Dump-control producer: counts frames after ROM download ends and derives
// the dump window (enable plus start/stop strobes) and a sticky finish
// request from configurable frame numbers.
module mist_frame_trig
    import mist_dump_pkg::*;
#(
    parameter int DUMP_START = 0,
    parameter int DUMP_LEN   = 0,
    parameter int MAXFRAME   = 0,
    parameter int CW         = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          downloading,
    output logic [CW-1:0] frame_cnt,
    output logic          frame_stb,
    output logic          dump_en,
    output logic          dump_start_stb,
    output logic          dump_stop_stb,
    output logic          sim_finish
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_PRE  = 2'(PRE);
    localparam logic [1:0] S_DUMP = 2'(DUMP);
    localparam logic [1:0] S_POST = 2'(POST);

    localparam logic [CW-1:0] CNT_MAX_C  = {CW{1'b1}};
    localparam logic [CW-1:0] START_C    = CW'(DUMP_START);
    localparam logic [CW-1:0] MAX_C      = CW'(MAXFRAME);
    // Stop frame is the CW-bit sum of start and length, pinned at all-ones on overflow.
    localparam logic [CW:0]   STOP_SUM_C = {1'b0, START_C} + (CW+1)'(DUMP_LEN);
    localparam logic [CW-1:0] STOP_C     = STOP_SUM_C[CW] ? CNT_MAX_C : STOP_SUM_C[CW-1:0];
    localparam bit START_AT_ZERO_C = (DUMP_START == 32'sd0);
    localparam bit LEN_BOUNDED_C   = (DUMP_LEN != 32'sd0);
    localparam bit FINISH_EN_C     = (MAXFRAME != 32'sd0);

    logic          fall_s;
    logic [CW-1:0] cnt_inc_s;

    logic [1:0]    state_q,          state_d;
    logic [CW-1:0] frame_cnt_q,      frame_cnt_d;
    logic          frame_stb_q,      frame_stb_d;
    logic          dump_en_q,        dump_en_d;
    logic          dump_start_stb_q, dump_start_stb_d;
    logic          dump_stop_stb_q,  dump_stop_stb_d;
    logic          sim_finish_q,     sim_finish_d;

    mist_vs_edge u_vs_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .vs       (vs),
        .fall_stb (fall_s)
    );

    // Saturating increment of the frame counter.
    always_comb begin
        if (frame_cnt_q == CNT_MAX_C) begin
            cnt_inc_s = frame_cnt_q;
        end else begin
            cnt_inc_s = frame_cnt_q + CW'(1);
        end
    end

    // Dump-window FSM: download gating, frame counting, window and finish decisions.
    always_comb begin
        state_d          = state_q;
        frame_cnt_d      = frame_cnt_q;
        frame_stb_d      = 1'b0;
        dump_en_d        = dump_en_q;
        dump_start_stb_d = 1'b0;
        dump_stop_stb_d  = 1'b0;
        sim_finish_d     = sim_finish_q;

        if (state_q == S_IDLE) begin
            // Counter is held at zero until the download ends; vs edges are ignored.
            frame_cnt_d = '0;
            if (!downloading) begin
                if (START_AT_ZERO_C) begin
                    state_d          = S_DUMP;
                    dump_en_d        = 1'b1;
                    dump_start_stb_d = 1'b1;
                end else begin
                    state_d = S_PRE;
                end
            end else begin
                state_d = S_IDLE;
            end
        end else if (downloading) begin
            // A new download restarts numbering; a frame edge in this cycle is dropped.
            state_d         = S_IDLE;
            frame_cnt_d     = '0;
            dump_en_d       = 1'b0;
            dump_stop_stb_d = dump_en_q;
        end else if (fall_s) begin
            frame_cnt_d = cnt_inc_s;
            frame_stb_d = 1'b1;
            if (FINISH_EN_C && (cnt_inc_s == MAX_C)) begin
                sim_finish_d = 1'b1;
            end else begin
                sim_finish_d = sim_finish_q;
            end
            case (state_q)
                S_PRE: begin
                    if (cnt_inc_s == START_C) begin
                        state_d          = S_DUMP;
                        dump_en_d        = 1'b1;
                        dump_start_stb_d = 1'b1;
                    end else begin
                        state_d = S_PRE;
                    end
                end
                S_DUMP: begin
                    if (LEN_BOUNDED_C && (cnt_inc_s == STOP_C)) begin
                        state_d         = S_POST;
                        dump_en_d       = 1'b0;
                        dump_stop_stb_d = 1'b1;
                    end else begin
                        state_d = S_DUMP;
                    end
                end
                S_POST: begin
                    state_d = S_POST;
                end
                default: begin
                    state_d   = S_IDLE;
                    dump_en_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; asynchronous reset drops everything without a stop strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            frame_cnt_q      <= '0;
            frame_stb_q      <= 1'b0;
            dump_en_q        <= 1'b0;
            dump_start_stb_q <= 1'b0;
            dump_stop_stb_q  <= 1'b0;
            sim_finish_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            frame_cnt_q      <= frame_cnt_d;
            frame_stb_q      <= frame_stb_d;
            dump_en_q        <= dump_en_d;
            dump_start_stb_q <= dump_start_stb_d;
            dump_stop_stb_q  <= dump_stop_stb_d;
            sim_finish_q     <= sim_finish_d;
        end
    end

    assign frame_cnt      = frame_cnt_q;
    assign frame_stb      = frame_stb_q;
    assign dump_en        = dump_en_q;
    assign dump_start_stb = dump_start_stb_q;
    assign dump_stop_stb  = dump_stop_stb_q;
    assign sim_finish     = sim_finish_q;

endmodule

// File: tb/tb_mist_frame_trig.sv
// Bench for mist_frame_trig: three configurations share one clock and one
// stimulus stream; a frame-level model predicts every output each cycle,
// and directed literal checks pin the model on the key scenarios.
module tb_mist_frame_trig;

    localparam int P_START [3] = '{0, 2, 2};
    localparam int P_LEN   [3] = '{0, 3, 0};
    localparam int P_MAX   [3] = '{0, 4, 0};
    localparam int P_CW    [3] = '{32, 32, 4};

    logic clk = 1'b0;
    logic rst_n, vs, downloading;

    logic [31:0] cnt0, cnt1;
    logic [3:0]  cnt2;
    logic stb0, stb1, stb2;
    logic en0, en1, en2;
    logic sst0, sst1, sst2;
    logic pst0, pst1, pst2;
    logic fin0, fin1, fin2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mist_frame_trig #(.DUMP_START(P_START[0]), .DUMP_LEN(P_LEN[0]), .MAXFRAME(P_MAX[0]), .CW(P_CW[0])) u0 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(cnt0), .frame_stb(stb0), .dump_en(en0),
        .dump_start_stb(sst0), .dump_stop_stb(pst0), .sim_finish(fin0));

    mist_frame_trig #(.DUMP_START(P_START[1]), .DUMP_LEN(P_LEN[1]), .MAXFRAME(P_MAX[1]), .CW(P_CW[1])) u1 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(cnt1), .frame_stb(stb1), .dump_en(en1),
        .dump_start_stb(sst1), .dump_stop_stb(pst1), .sim_finish(fin1));

    mist_frame_trig #(.DUMP_START(P_START[2]), .DUMP_LEN(P_LEN[2]), .MAXFRAME(P_MAX[2]), .CW(P_CW[2])) u2 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(cnt2), .frame_stb(stb2), .dump_en(en2),
        .dump_start_stb(sst2), .dump_stop_stb(pst2), .sim_finish(fin2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // vs history: smp[0] = value at previous edge, smp[2] = three edges back.
    bit     smp [3];
    bit     m_act [3], m_started [3], m_stopped [3], m_fin [3];
    bit     m_en [3], m_stb [3], m_sst [3], m_pst [3];
    longint m_cnt [3];

    always @(posedge clk) begin : model
        bit     fall, en_new, was_started;
        longint mx, stopv;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                smp[i] = 1'b0;
                m_act[i] = 1'b0; m_started[i] = 1'b0; m_stopped[i] = 1'b0; m_fin[i] = 1'b0;
                m_en[i] = 1'b0; m_stb[i] = 1'b0; m_sst[i] = 1'b0; m_pst[i] = 1'b0;
                m_cnt[i] = 0;
            end
        end else begin
            // A frame ends here if vs was high three edges ago and low two edges ago.
            fall   = smp[2] && !smp[1];
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = vs;
            for (int i = 0; i < 3; i++) begin
                mx    = (longint'(1) << P_CW[i]) - 1;
                stopv = P_START[i] + P_LEN[i];
                if (stopv > mx) stopv = mx;
                m_stb[i] = 1'b0;
                if (!m_act[i]) begin
                    if (!downloading) begin
                        m_act[i]     = 1'b1;
                        m_cnt[i]     = 0;
                        m_started[i] = (P_START[i] == 0);
                        m_stopped[i] = 1'b0;
                    end
                end else if (downloading) begin
                    m_act[i] = 1'b0;
                    m_cnt[i] = 0;
                end else if (fall) begin
                    was_started = m_started[i];
                    m_cnt[i] = (m_cnt[i] == mx) ? mx : m_cnt[i] + 1;
                    m_stb[i] = 1'b1;
                    if (P_MAX[i] != 0 && m_cnt[i] == P_MAX[i]) m_fin[i] = 1'b1;
                    if (P_LEN[i] != 0 && was_started && m_cnt[i] == stopv) m_stopped[i] = 1'b1;
                    if (m_cnt[i] == P_START[i]) m_started[i] = 1'b1;
                end
                en_new   = m_act[i] && m_started[i] && !m_stopped[i];
                m_sst[i] = en_new && !m_en[i];
                m_pst[i] = !en_new && m_en[i];
                m_en[i]  = en_new;
            end
        end
    end

    function automatic logic [63:0] dcnt(input int i);
        if (i == 0) return {32'd0, cnt0};
        else if (i == 1) return {32'd0, cnt1};
        else return {60'd0, cnt2};
    endfunction

    function automatic logic [4:0] douts(input int i);
        // {stb, en, start, stop, finish}
        if (i == 0) return {stb0, en0, sst0, pst0, fin0};
        else if (i == 1) return {stb1, en1, sst1, pst1, fin1};
        else return {stb2, en2, sst2, pst2, fin2};
    endfunction

    // Every-cycle comparison of all three DUTs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.frame_cnt", i), dcnt(i), m_cnt[i]);
                chk($sformatf("u%0d.outs{stb,en,sst,pst,fin}", i), 64'(douts(i)),
                    64'({m_stb[i], m_en[i], m_sst[i], m_pst[i], m_fin[i]}));
            end
        end
    end

    // Pulse counters for the saturation phase.
    bit p4 = 1'b0;
    int u2_starts = 0;
    int u2_stbs   = 0;
    always @(negedge clk) begin
        if (p4) begin
            if (sst2) u2_starts++;
            if (stb2) u2_stbs++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame;
        vs = 1'b1;
        repeat (4) tick;
        vs = 1'b0;
        repeat (4) tick;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        vs = 1'b0;
        downloading = 1'b0;
        repeat (3) tick;
        chk("rst.u1.frame_cnt", 64'(cnt1), 64'd0);
        chk("rst.u0.dump_en", 64'(en0), 64'd0);
        chk("rst.u0.start_stb", 64'(sst0), 64'd0);
        chk("rst.u1.finish", 64'(fin1), 64'd0);
        chk("rst.u0.frame_stb", 64'(stb0), 64'd0);

        // Release with vs low and no download: u0 opens at once.
        rst_n = 1'b1;
        tick;
        chk("rel.u0.dump_en", 64'(en0), 64'd1);
        chk("rel.u0.start_stb", 64'(sst0), 64'd1);
        chk("rel.u1.dump_en", 64'(en1), 64'd0);
        repeat (5) tick;
        chk("rel.u0.no_frame", 64'(cnt0), 64'd0);

        // First genuine vs fall: strobe on the 3rd rising clk.
        vs = 1'b1;
        repeat (4) tick;
        vs = 1'b0;
        n = 0;
        do begin tick; n++; end while (!stb0 && n < 10);
        chk("vs_fall_latency", 64'(n), 64'd3);
        repeat (3) tick;
        repeat (5) frame;
        chk("win.u1.frame_cnt", 64'(cnt1), 64'd6);
        chk("win.u1.dump_en_closed", 64'(en1), 64'd0);
        chk("win.u1.finish", 64'(fin1), 64'd1);

        // Long download with vs activity: counters pinned at 0, finish sticky.
        downloading = 1'b1;
        tick;
        repeat (3) frame;
        repeat (975) tick;
        chk("dl.u1.frame_cnt", 64'(cnt1), 64'd0);
        chk("dl.u0.frame_cnt", 64'(cnt0), 64'd0);
        chk("dl.u1.finish_sticky", 64'(fin1), 64'd1);
        downloading = 1'b0;
        tick;
        repeat (3) tick;

        // Start strobe on the 2nd frame after download, 3 clks after that vs fall.
        frame;
        vs = 1'b1;
        repeat (4) tick;
        vs = 1'b0;
        n = 0;
        do begin tick; n++; end while (!sst1 && n < 10);
        chk("start_latency", 64'(n), 64'd3);
        chk("start.u1.frame_cnt", 64'(cnt1), 64'd2);
        repeat (2) tick;
        frame;
        chk("pre_abort.u1.frame_cnt", 64'(cnt1), 64'd3);
        chk("pre_abort.u1.dump_en", 64'(en1), 64'd1);

        // Download rises in the same cycle a frame strobe would be produced.
        vs = 1'b1;
        repeat (4) tick;
        vs = 1'b0;
        repeat (2) tick;
        downloading = 1'b1;
        tick;
        chk("abort.u1.frame_cnt", 64'(cnt1), 64'd0);
        chk("abort.u1.dump_en", 64'(en1), 64'd0);
        chk("abort.u1.stop_stb", 64'(pst1), 64'd1);
        chk("abort.u1.frame_stb", 64'(stb1), 64'd0);
        repeat (5) tick;
        downloading = 1'b0;
        tick;

        // Twenty frames: CW=4 instance saturates at 15 and keeps strobing.
        p4 = 1'b1;
        repeat (20) frame;
        p4 = 1'b0;
        chk("sat.u2.frame_cnt", 64'(cnt2), 64'd15);
        chk("sat.u2.start_count", 64'(u2_starts), 64'd1);
        chk("sat.u2.stb_count", 64'(u2_stbs), 64'd20);
        chk("sat.u0.frame_cnt", 64'(cnt0), 64'd20);
        chk("post.u1.dump_en", 64'(en1), 64'd0);

        // Asynchronous reset with u0's window open: immediate drop, no stop strobe.
        chk("prereset.u0.dump_en", 64'(en0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("areset.u0.dump_en", 64'(en0), 64'd0);
        chk("areset.u0.stop_stb", 64'(pst0), 64'd0);
        chk("areset.u2.frame_cnt", 64'(cnt2), 64'd0);
        chk("areset.u1.finish", 64'(fin1), 64'd0);
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (2) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
